fpcvt_sched: RTL and testbench

- Shares one combinational 12-bit-to-8-bit floating-point converter (`main`) among NREQ requesters.
- Arbitrates valid/ready requests round-robin and registers the selected sample into a 2-stage pipeline.
- Returns each converted byte tagged with the ID of the requester that sent it.
- Sits between sample producers and downstream consumers; it is the only instantiation point of `main`.

---
 rtl/fpcvt_sched.sv | 127 ++++++++++++
 tb/tb_fpcvt_sched.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpcvt_sched.sv
// Round-robin scheduler that shares one 12-bit to 8-bit floating-point converter
// among NREQ valid/ready requesters through a two-stage stallable pipeline.
module fpcvt_sched #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [12*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 out_valid,
   output logic [7:0]           out_data,
   output logic [IDW-1:0]       out_id,
   input  logic                 out_ready
);

   // Converter: sign/magnitude, 4-bit significand scaled by 2^exp, round half up.
   function automatic logic [7:0] main(input logic [11:0] smp);
      logic [11:0] mag;
      logic [3:0]  lz;
      logic [3:0]  e;
      logic [4:0]  s;
      logic [7:0]  cvt;
      if (smp == 12'h800)
         mag = 12'h7FF;
      else if (smp[11])
         mag = -smp;
      else
         mag = smp;
      lz = 4'd12;
      for (int b = 0; b < 12; b++)
         if (mag[b]) lz = 4'(11 - b);
      if (lz >= 4'd8) begin
         e = 4'd0;
         s = {1'b0, mag[3:0]};
      end else begin
         e = 4'd8 - lz;
         s = {1'b0, 4'(mag >> e)} + {4'b0000, mag[e - 4'd1]};
         if (s[4]) begin
            s = 5'b01000;
            e = e + 4'd1;
         end
      end
      if (e > 4'd7)
         cvt = {smp[11], 7'b111_1111};
      else
         cvt = {smp[11], e[2:0], s[3:0]};
      return cvt;
   endfunction

   logic [11:0]    req_smp [NREQ];
   logic           s1_v_q;
   logic [11:0]    s1_smp_q;
   logic [IDW-1:0] s1_id_q;
   logic           out_valid_q;
   logic [7:0]     out_data_q;
   logic [IDW-1:0] out_id_q;
   logic [IDW-1:0] ptr_q;
   logic [IDW-1:0] ptr_d;
   logic [IDW-1:0] gnt_id;
   logic           gnt_any;
   logic           s2_adv;
   logic           s1_adv;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_smp[gi]   = req_data[12*gi +: 12];
      assign req_ready[gi] = gnt_any && (gnt_id == IDW'(gi)) && s1_adv && !rst;
   end

   assign s2_adv = !out_valid_q || out_ready;
   assign s1_adv = !s1_v_q || s2_adv;

   // Smallest distance above the pointer (with wrap) wins the grant.
   always_comb begin
      int off;
      int best;
      off     = 0;
      best    = NREQ;
      gnt_any = 1'b0;
      gnt_id  = '0;
      for (int i = 0; i < NREQ; i++) begin
         off = i - int'(ptr_q);
         if (off < 0) off = off + NREQ;
         if (req_valid[i] && off < best) begin
            best    = off;
            gnt_any = 1'b1;
            gnt_id  = IDW'(i);
         end
      end
   end

   assign ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v_q      <= 1'b0;
         s1_smp_q    <= '0;
         s1_id_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         ptr_q       <= '0;
      end else begin
         if (s2_adv) begin
            out_valid_q <= s1_v_q;
            if (s1_v_q) begin
               out_data_q <= main(s1_smp_q);
               out_id_q   <= s1_id_q;
            end
         end
         if (s1_adv) begin
            s1_v_q <= gnt_any;
            if (gnt_any) begin
               s1_smp_q <= req_smp[gnt_id];
               s1_id_q  <= gnt_id;
               ptr_q    <= ptr_d;
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;

endmodule

// File: tb/tb_fpcvt_sched.sv
// Bench for fpcvt_sched: conversion table, directed arbitration/stall/reset
// sequences, and randomized traffic against a scoreboard with a reference model.
module tb_fpcvt_sched;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [12*NREQ-1:0]  req_data;
   logic [NREQ-1:0]     req_ready;
   logic                out_valid;
   logic [7:0]          out_data;
   logic [IDW-1:0]      out_id;
   logic                out_ready;

   always #5 clk = ~clk;

   fpcvt_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_data (req_data),
      .req_ready(req_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_id   (out_id),
      .out_ready(out_ready)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0]     data;
      logic [IDW-1:0] id;
   } res_t;

   typedef struct {
      logic [11:0] din;
      logic [7:0]  dout;
   } vec_t;

   res_t           sb_q[$];
   int             m_ptr;
   logic           prev_stall;
   logic [7:0]     prev_data;
   logic [IDW-1:0] prev_id;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Value-level model: pick the scale so mag/2^e lands in [8,16), round half up.
   function automatic logic [7:0] ref_cvt(input logic [11:0] x);
      int v, mag, e, sig, sgn;
      v   = x[11] ? int'(x) - 4096 : int'(x);
      sgn = (v < 0) ? 1 : 0;
      mag = (v < 0) ? -v : v;
      if (mag > 2047) mag = 2047;
      if (mag < 16) begin
         e   = 0;
         sig = mag;
      end else begin
         e = 0;
         while ((mag >> (e + 4)) != 0) e++;
         sig = (mag + (1 << (e - 1))) >> e;
         if (sig == 16) begin
            sig = 8;
            e   = e + 1;
         end
         if (e > 7) begin
            e   = 7;
            sig = 15;
         end
      end
      return 8'((sgn << 7) | (e << 4) | sig);
   endfunction

   function automatic logic [11:0] rand_sample();
      logic [11:0] edges [10];
      edges = '{12'd0, 12'd1, 12'd15, 12'd16, 12'd31, 12'd2047, 12'h800, 12'hFFF, 12'd1000, 12'hF9C};
      if ($urandom_range(0, 3) == 0)
         return edges[$urandom_range(0, 9)];
      return 12'($urandom_range(0, 4095));
   endfunction

   // Monitor: arbitration model, output stability, and in-order scoreboard.
   always @(negedge clk) begin
      logic [NREQ-1:0] exp_rdy;
      logic [NREQ-1:0] hs;
      res_t            r;
      int              c;
      if (rst) begin
         check("ready_in_reset", int'(req_ready), 0);
         sb_q.delete();
         m_ptr      = 0;
         prev_stall = 1'b0;
      end else begin
         exp_rdy = '0;
         // At most two samples fit in flight; a full pipe only moves when downstream takes one.
         if ((sb_q.size() < 2) || out_ready) begin
            for (int s = 0; s < NREQ; s++) begin
               c = (m_ptr + s) % NREQ;
               if (((req_valid >> c) & NREQ'(1)) != 0) begin
                  exp_rdy = NREQ'(1) << c;
                  break;
               end
            end
         end
         check("grant", int'(req_ready), int'(exp_rdy));
         if (prev_stall) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_data", int'({out_id, out_data}), int'({prev_id, prev_data}));
         end
         if (out_valid && out_ready) begin
            check("out_expected", int'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
               r = sb_q.pop_front();
               check("out_data", int'(out_data), int'(r.data));
               check("out_id", int'(out_id), int'(r.id));
            end
         end
         hs = req_valid & req_ready;
         for (int i = 0; i < NREQ; i++) begin
            if (((hs >> i) & NREQ'(1)) != 0) begin
               r.data = ref_cvt(req_data[12*i +: 12]);
               r.id   = IDW'(i);
               sb_q.push_back(r);
               m_ptr = (i + 1) % NREQ;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_id    = out_id;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [11:0] d);
      req_valid[i]         = v;
      req_data[12*i +: 12] = d;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t            tbl [13];
      int              exp_ord [3];
      int              got [$];
      int              acc, cnt, w, idx;
      logic [7:0]      hold_d;
      logic [IDW-1:0]  hold_i;
      logic [NREQ-1:0] hs;

      tbl[0]  = '{12'd44,   8'b0_010_1011};
      tbl[1]  = '{12'd45,   8'b0_010_1011};
      tbl[2]  = '{12'd46,   8'b0_010_1100};
      tbl[3]  = '{12'd47,   8'b0_010_1100};
      tbl[4]  = '{12'd2047, 8'b0_111_1111};
      tbl[5]  = '{12'h800,  8'b1_111_1111};
      tbl[6]  = '{12'hFFF,  8'b1_000_0001};
      tbl[7]  = '{12'd0,    8'b0_000_0000};
      tbl[8]  = '{12'd15,   8'b0_000_1111};
      tbl[9]  = '{12'd16,   8'b0_001_1000};
      tbl[10] = '{12'd31,   8'b0_010_1000};
      tbl[11] = '{12'd1000, 8'b0_111_1000};
      tbl[12] = '{12'hF9C,  8'b1_011_1101};
      exp_ord = '{2, 3, 1};

      rst       = 1'b1;
      req_data  = '0;
      req_valid = '1;
      out_ready = 1'b1;
      tick();
      tick();
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_out_id", int'(out_id), 0);
      check("rst_ready", int'(req_ready), 0);
      req_valid = '0;
      rst       = 1'b0;
      tick();

      // Conversion table through requester 0, with the two-edge latency checked.
      for (int t = 0; t < 13; t++) begin
         set_req(0, 1'b1, tbl[t].din);
         @(negedge clk);
         check("tbl_accept", int'(req_ready[0]), 1);
         tick();
         set_req(0, 1'b0, 12'd0);
         check("tbl_not_yet", int'(out_valid), 0);
         tick();
         check("tbl_valid", int'(out_valid), 1);
         check("tbl_data", int'(out_data), int'(tbl[t].dout));
         check("tbl_id", int'(out_id), 0);
      end
      tick();

      // Round robin with every requester valid.
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 12'(100 * i + 7));
      w = 0;
      while (!out_valid && w < 10) begin
         tick();
         w++;
      end
      check("rr_start", int'(out_valid), 1);
      for (int k = 0; k < 6; k++) begin
         check("rr_valid", int'(out_valid), 1);
         check("rr_id", int'(out_id), k % NREQ);
         tick();
      end
      req_valid = '0;
      repeat (4) tick();

      // Backpressure: two accepts fill S1+S2, then nothing moves.
      out_ready = 1'b0;
      req_valid = '1;
      acc = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         acc += $countones(req_ready);
         if (c == 2) begin
            hold_d = out_data;
            hold_i = out_id;
         end
         if (c == 4) begin
            check("bp_full", int'(out_valid), 1);
            check("bp_stable_data", int'(out_data), int'(hold_d));
            check("bp_stable_id", int'(out_id), int'(hold_i));
         end
         tick();
      end
      check("bp_accepts", acc, 2);
      req_valid = '0;
      out_ready = 1'b1;
      cnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid && out_ready) cnt++;
         tick();
      end
      check("bp_drain", cnt, 2);

      // Pointer does not move during a stall with no handshake.
      do_reset();
      out_ready = 1'b0;
      req_valid = 4'b0011;
      @(negedge clk);
      check("ph_g0", int'(req_ready), 1);
      tick();
      req_valid = 4'b0010;
      @(negedge clk);
      check("ph_g1", int'(req_ready), 2);
      tick();
      req_valid = 4'b0100;
      repeat (3) begin
         @(negedge clk);
         check("ph_stall", int'(req_ready), 0);
         tick();
      end
      req_valid = 4'b1110;
      out_ready = 1'b1;
      w = 0;
      while (got.size() < 3 && w < 12) begin
         @(negedge clk);
         idx = -1;
         for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
         if (idx >= 0) got.push_back(idx);
         tick();
         if (idx >= 0) req_valid[idx] = 1'b0;
         w++;
      end
      check("ph_count", got.size(), 3);
      for (int k = 0; k < 3; k++)
         if (k < got.size()) check("ph_order", got[k], exp_ord[k]);
      req_valid = '0;
      repeat (4) tick();

      // Reset with both stages full; pointer left non-zero beforehand.
      out_ready = 1'b0;
      req_valid = 4'b0110;
      cnt = 0;
      w = 0;
      while (cnt < 2 && w < 8) begin
         @(negedge clk);
         hs = req_valid & req_ready;
         tick();
         for (int i = 0; i < NREQ; i++) if (hs[i]) begin
            req_valid[i] = 1'b0;
            cnt++;
         end
         w++;
      end
      check("mid_accepts", cnt, 2);
      check("mid_full", int'(out_valid), 1);
      req_valid = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_valid", int'(out_valid), 0);
      check("mid_rst_data", int'(out_data), 0);
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("mid_no_stale", int'(out_valid), 0);
         tick();
      end
      req_valid = 4'b1010;
      @(negedge clk);
      check("mid_first_grant", int'(req_ready), 2);
      tick();
      req_valid = '0;
      repeat (4) tick();

      // Randomized traffic; requesters hold valid and data until handshake.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         hs = req_valid & req_ready;
         tick();
         rst       = ($urandom_range(0, 299) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || hs[i]) begin
               if ($urandom_range(0, 2) != 0)
                  set_req(i, 1'b1, rand_sample());
               else
                  set_req(i, 1'b0, 12'd0);
            end
         end
      end
      rst       = 1'b0;
      req_valid = '0;
      out_ready = 1'b1;
      repeat (6) tick();
      check("sb_empty", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
